// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined execute-stage ALU: unit selects,
// per-unit function codes and the sequencing state.
package alu_pkg;

  localparam logic [2:0] SHIFT_REG   = 3'b000;
  localparam logic [2:0] ARITH_LOGIC = 3'b001;
  localparam logic [2:0] MUL         = 3'b010;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] HADD = 3'b001;
  localparam logic [2:0] SUB  = 3'b010;
  localparam logic [2:0] NOT  = 3'b011;
  localparam logic [2:0] AND  = 3'b100;
  localparam logic [2:0] OR   = 3'b101;
  localparam logic [2:0] XOR  = 3'b110;
  localparam logic [2:0] LHG  = 3'b111;

  localparam logic [2:0] SHLEFTLOG = 3'b000;
  localparam logic [2:0] SHLEFTART = 3'b001;
  localparam logic [2:0] SHRGHTLOG = 3'b010;
  localparam logic [2:0] SHRGHTART = 3'b011;
  localparam logic [2:0] ROTL      = 3'b100;
  localparam logic [2:0] ROTR      = 3'b101;

  localparam logic [2:0] MULLO = 3'b000;
  localparam logic [2:0] MULHI = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic logic is_mul_op(input logic [2:0] sel, input logic [2:0] op);
    return (sel == MUL) && ((op == MULLO) || (op == MULHI));
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add signed multiplier working on operand magnitudes; the
// product sign is restored combinationally from the captured operand signs.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic               busy_r;
  logic [CW-1:0]      cnt_r;
  logic               neg_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;

  assign mag_a_s = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
  assign mag_b_s = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;
  assign done    = busy_r && (cnt_r == CNT_LAST);
  assign product = neg_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;

  // Start performs bit 0 of the multiplier; each busy cycle handles one more bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_r   <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      neg_r    <= 1'b0;
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
    end else if (start) begin
      busy_r   <= 1'b1;
      cnt_r    <= CNT_ONE;
      neg_r    <= a[WIDTH-1] ^ b[WIDTH-1];
      acc_r    <= mag_b_s[0] ? {{WIDTH{1'b0}}, mag_a_s} : {(2*WIDTH){1'b0}};
      mcand_r  <= {{(WIDTH-1){1'b0}}, mag_a_s, 1'b0};
      mplier_r <= {1'b0, mag_b_s[WIDTH-1:1]};
    end else if (busy_r) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CNT_ONE;
      if (done) begin
        busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU: single-cycle shift/arith/logic ops and an
// iterative signed multiply, all delivered through one registered result.
module alu_pipe import alu_pkg::*; #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] aluin1,
  input  logic [WIDTH-1:0] aluin2,
  input  logic [2:0]       opselect,
  input  logic [2:0]       operation,
  input  logic [SHW-1:0]   shift_number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  localparam int H = WIDTH / 2;
  localparam logic [SHW:0] W_AMT = (SHW + 1)'(WIDTH);

  state_t             state_r, state_nx_s;
  logic               mulhi_r;
  logic               in_fire_s, start_s, mul_done_s;
  logic [2*WIDTH-1:0] product_s;
  logic [WIDTH:0]     add_s, sub_s, shl_ext_s, shr_ext_s;
  logic [H:0]         hlow_s;
  logic [H-1:0]       hhigh_s;
  logic [SHW:0]       back_s;
  logic [WIDTH-1:0]   sra_s, rotl_s, rotr_s;
  logic [WIDTH-1:0]   res_s, mul_res_s;
  logic               cy_s, ov_s, ill_s, mul_ov_s;

  assign in_ready  = (state_r == S_IDLE) && (!out_valid || out_ready);
  assign in_fire_s = in_valid && in_ready;
  assign start_s   = in_fire_s && is_mul_op(opselect, operation);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (start_s),
    .a       (aluin1),
    .b       (aluin2),
    .done    (mul_done_s),
    .product (product_s)
  );

  // Half-add upper half is the sign-extension sum plus the carry out of the low half.
  assign add_s     = {1'b0, aluin1} + {1'b0, aluin2};
  assign sub_s     = {1'b0, aluin1} - {1'b0, aluin2};
  assign hlow_s    = {1'b0, aluin1[H-1:0]} + {1'b0, aluin2[H-1:0]};
  assign hhigh_s   = {H{aluin1[H-1]}} + {H{aluin2[H-1]}} + {{(H-1){1'b0}}, hlow_s[H]};
  assign shl_ext_s = {1'b0, aluin1} << shift_number;
  assign shr_ext_s = {aluin1, 1'b0} >> shift_number;
  assign sra_s     = $signed(aluin1) >>> shift_number;
  assign back_s    = W_AMT - {1'b0, shift_number};
  assign rotl_s    = (aluin1 << shift_number) | (aluin1 >> back_s);
  assign rotr_s    = (aluin1 >> shift_number) | (aluin1 << back_s);

  // Single-cycle result and flags; the extended shifts carry the last bit out.
  always_comb begin
    res_s = {WIDTH{1'b0}};
    cy_s  = 1'b0;
    ov_s  = 1'b0;
    ill_s = 1'b0;
    case (opselect)
      ARITH_LOGIC: begin
        case (operation)
          ADD: begin
            res_s = add_s[WIDTH-1:0];
            cy_s  = add_s[WIDTH];
            ov_s  = (aluin1[WIDTH-1] == aluin2[WIDTH-1]) && (add_s[WIDTH-1] != aluin1[WIDTH-1]);
          end
          HADD: begin
            res_s = {hhigh_s, hlow_s[H-1:0]};
            cy_s  = hlow_s[H];
          end
          SUB: begin
            res_s = sub_s[WIDTH-1:0];
            cy_s  = sub_s[WIDTH];
            ov_s  = (aluin1[WIDTH-1] != aluin2[WIDTH-1]) && (sub_s[WIDTH-1] != aluin1[WIDTH-1]);
          end
          NOT:     res_s = ~aluin1;
          AND:     res_s = aluin1 & aluin2;
          OR:      res_s = aluin1 | aluin2;
          XOR:     res_s = aluin1 ^ aluin2;
          LHG:     res_s = {aluin2[H-1:0], {H{1'b0}}};
          default: ill_s = 1'b1;
        endcase
      end
      SHIFT_REG: begin
        case (operation)
          SHLEFTLOG, SHLEFTART: begin
            res_s = shl_ext_s[WIDTH-1:0];
            cy_s  = shl_ext_s[WIDTH];
          end
          SHRGHTLOG: begin
            res_s = shr_ext_s[WIDTH:1];
            cy_s  = shr_ext_s[0];
          end
          SHRGHTART: begin
            res_s = sra_s;
            cy_s  = shr_ext_s[0];
          end
          ROTL: begin
            res_s = rotl_s;
            cy_s  = shl_ext_s[WIDTH];
          end
          ROTR: begin
            res_s = rotr_s;
            cy_s  = shr_ext_s[0];
          end
          default: ill_s = 1'b1;
        endcase
      end
      MUL: begin
        if (is_mul_op(opselect, operation)) begin
          ill_s = 1'b0;
        end else begin
          ill_s = 1'b1;
        end
      end
      default: ill_s = 1'b1;
    endcase
  end

  // Multiplier result selection; the low half overflows when the upper bits are not pure sign.
  always_comb begin
    mul_res_s = product_s[WIDTH-1:0];
    mul_ov_s  = 1'b0;
    if (mulhi_r) begin
      mul_res_s = product_s[2*WIDTH-1:WIDTH];
    end else begin
      mul_ov_s = !((&product_s[2*WIDTH-1:WIDTH-1]) || !(|product_s[2*WIDTH-1:WIDTH-1]));
    end
  end

  // Next-state logic for the multiply sequencing.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_s) state_nx_s = S_MUL;
        else         state_nx_s = S_IDLE;
      end
      S_MUL: begin
        if (mul_done_s) state_nx_s = S_DONE;
        else            state_nx_s = S_MUL;
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register and the high/low selector captured with the multiply operands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      mulhi_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (start_s) begin
        mulhi_r <= (operation == MULHI);
      end
    end
  end

  // Result register: loads on a single-cycle accept or multiply completion, else holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      aluout    <= {WIDTH{1'b0}};
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
    end else if (state_r == S_DONE) begin
      out_valid <= 1'b1;
      aluout    <= mul_res_s;
      carryout  <= 1'b0;
      overflow  <= mul_ov_s;
      zero      <= (mul_res_s == {WIDTH{1'b0}});
      illegal   <= 1'b0;
    end else if (in_fire_s && !start_s) begin
      out_valid <= 1'b1;
      aluout    <= res_s;
      carryout  <= cy_s;
      overflow  <= ov_s;
      zero      <= (res_s == {WIDTH{1'b0}});
      illegal   <= ill_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: expected results queued at each accepted
// operation and checked in order as results leave the block.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] aluin1, aluin2, aluout;
  logic [2:0]   opselect, operation;
  logic [4:0]   shift_number;
  logic         carryout, overflow, zero, illegal;

  alu_pipe #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .aluin1       (aluin1),
    .aluin2       (aluin2),
    .opselect     (opselect),
    .operation    (operation),
    .shift_number (shift_number),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .aluout       (aluout),
    .carryout     (carryout),
    .overflow     (overflow),
    .zero         (zero),
    .illegal      (illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] out;
    logic         c;
    logic         v;
    logic         z;
    logic         ill;
  } res_t;

  res_t q[$];
  res_t cur, prev, exp_r;
  logic prev_stall = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output side: in-order scoreboard pop on each transfer out, plus hold check while stalled.
  always @(negedge clock) begin
    cur = {aluout, carryout, overflow, zero, illegal};
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold_while_stalled", {out_valid, cur}, {1'b1, prev});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("result_without_op", {63'd0, out_valid}, 64'd0);
        end else begin
          exp_r = q.pop_front();
          chk("result", cur, exp_r);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev       = cur;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic [2:0] sel, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh,
                       input logic [W-1:0] eo, input logic ec, input logic ev, input logic ei);
    logic ok;
    res_t e;
    opselect = sel; operation = op; aluin1 = a; aluin2 = b; shift_number = sh;
    in_valid = 1'b1;
    ok = 1'b0;
    e = {eo, ec, ev, (eo == 32'h0), ei};
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock);
      if (in_ready) begin
        q.push_back(e);
        ok = 1'b1;
      end
    end
    chk("accept_timeout", {63'd0, ok}, 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    aluin1 = $urandom(); aluin2 = $urandom(); shift_number = 5'($urandom());
  endtask

  logic [W-1:0] sa, sb;
  logic [W:0]   ssum;

  initial begin
    in_valid = 1'b0; out_ready = 1'b1;
    aluin1 = 32'h0; aluin2 = 32'h0; opselect = 3'b000; operation = 3'b000; shift_number = 5'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_flags", {aluout, carryout, overflow, zero, illegal}, {32'h0, 4'b0010});
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clock); #1;

    issue(ARITH_LOGIC, ADD, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    chk("add_latency", {63'd0, out_valid}, 64'd1);
    issue(ARITH_LOGIC, SUB,  32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    issue(ARITH_LOGIC, SUB,  32'h00000001, 32'h00000002, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    issue(ARITH_LOGIC, ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    issue(ARITH_LOGIC, HADD, 32'h1234FFFF, 32'hABCD0001, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    issue(ARITH_LOGIC, HADD, 32'h00007FFF, 32'h00000001, 5'd0, 32'h00008000, 1'b0, 1'b0, 1'b0);
    issue(ARITH_LOGIC, NOT,  32'h0F0F0000, 32'h00000000, 5'd0, 32'hF0F0FFFF, 1'b0, 1'b0, 1'b0);
    issue(ARITH_LOGIC, AND,  32'hFF00FF00, 32'h0FF00FF0, 5'd0, 32'h0F000F00, 1'b0, 1'b0, 1'b0);
    issue(ARITH_LOGIC, OR,   32'hFF00FF00, 32'h0FF00FF0, 5'd0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
    issue(ARITH_LOGIC, XOR,  32'hFF00FF00, 32'h0FF00FF0, 5'd0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0);
    issue(ARITH_LOGIC, LHG,  32'h55555555, 32'h1234ABCD, 5'd0, 32'hABCD0000, 1'b0, 1'b0, 1'b0);
    issue(SHIFT_REG, SHRGHTART, 32'h80000010, 32'h0, 5'd4, 32'hF8000001, 1'b0, 1'b0, 1'b0);
    issue(SHIFT_REG, ROTL,      32'h80000001, 32'h0, 5'd1, 32'h00000003, 1'b1, 1'b0, 1'b0);
    issue(SHIFT_REG, SHLEFTLOG, 32'h12345678, 32'h0, 5'd0, 32'h12345678, 1'b0, 1'b0, 1'b0);
    issue(SHIFT_REG, SHLEFTART, 32'h40000001, 32'h0, 5'd2, 32'h00000004, 1'b1, 1'b0, 1'b0);
    issue(SHIFT_REG, SHRGHTLOG, 32'h8000000F, 32'h0, 5'd2, 32'h20000003, 1'b1, 1'b0, 1'b0);
    issue(SHIFT_REG, ROTR,      32'h00000001, 32'h0, 5'd1, 32'h80000000, 1'b1, 1'b0, 1'b0);
    issue(SHIFT_REG, 3'b110,    32'h12345678, 32'h0, 5'd3, 32'h00000000, 1'b0, 1'b0, 1'b1);

    // Multiply latency: 32 cycles not ready, result on the 33rd.
    issue(MUL, MULLO, 32'hFFFFFFFD, 32'h00000005, 5'd0, 32'hFFFFFFF1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      chk("mul_busy_in_ready", {63'd0, in_ready}, 64'd0);
      chk("mul_busy_out_valid", {63'd0, out_valid}, 64'd0);
    end
    @(negedge clock);
    chk("mul_out_valid", {63'd0, out_valid}, 64'd1);
    chk("mul_done_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clock); #1;
    issue(MUL, MULHI, 32'hFFFFFFFD, 32'h00000005, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    issue(MUL, MULLO, 32'h00010000, 32'h00010000, 5'd0, 32'h00000000, 1'b0, 1'b1, 1'b0);
    issue(MUL, MULHI, 32'h80000000, 32'h80000000, 5'd0, 32'h40000000, 1'b0, 1'b0, 1'b0);
    issue(MUL, MULLO, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    issue(MUL, MULLO, 32'h00000007, 32'hFFFFFFF7, 5'd0, 32'hFFFFFFC1, 1'b0, 1'b0, 1'b0);
    issue(MUL, 3'b011,  32'h00000007, 32'h00000003, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1);

    // Back-to-back adds with the consumer stalling for three cycles.
    fork
      begin
        repeat (2) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join_none
    for (int i = 1; i <= 4; i++) begin
      sa = 32'h11111111 * i;
      sb = 32'h01010101 + i;
      ssum = {1'b0, sa} + {1'b0, sb};
      issue(ARITH_LOGIC, ADD, sa, sb, 5'd0, ssum[W-1:0], ssum[W], 1'b0, 1'b0);
    end

    // Reset in the middle of a multiply discards it entirely.
    issue(MUL, MULLO, 32'h00000007, 32'h00000009, 5'd0, 32'h0000003F, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    q.delete();
    @(negedge clock);
    chk("mid_mul_rst_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 40; i++) begin
      chk("no_result_after_rst", {63'd0, out_valid}, 64'd0);
      @(negedge clock);
    end
    @(posedge clock); #1;
    issue(ARITH_LOGIC, AND, 32'hF0F0F0F0, 32'h3C3C3C3C, 5'd0, 32'h30303030, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 3'b000, 32'h12345678, 32'h9ABCDEF0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 50 && q.size() != 0; n++) @(negedge clock);
    @(negedge clock);
    chk("drain", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the single-cycle execute-stage ALU. It adds configurable datapath width, valid/ready flow control on input and output, and a registered result with carry, overflow and zero flags. It also adds an iterative signed multiplier mode and rotate operations. It sits between the decode/issue stage and writeback, so the issue logic can stall on it.

## Interface
Parameters:
- WIDTH, 32: datapath width; even, ≥ 8.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts the operation this cycle.
- aluin1  in  WIDTH  operand A (signed).
- aluin2  in  WIDTH  operand B (signed).
- opselect  in  3  unit: SHIFT_REG 000, ARITH_LOGIC 001, MUL 010; others illegal.
- operation  in  3  function within the unit.
- shift_number  in  SHW  shift/rotate amount.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer takes the result.
- aluout  out  WIDTH  result.
- carryout  out  1  carry/borrow/last-bit-out.
- overflow  out  1  signed overflow.
- zero  out  1  aluout == 0.
- illegal  out  1  the result came from an illegal opselect/operation.

## Operation
- A transfer in occurs when in_valid && in_ready. A transfer out occurs when out_valid && out_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- ARITH_LOGIC:
  - ADD 000: A+B. carryout = unsigned carry out of the MSB. overflow = signed overflow.
  - HADD 001: sign-extended low halves added. carryout = carry out of bit WIDTH/2-1.
  - SUB 010: A−B. carryout = 1 on unsigned borrow (A<B). overflow = signed overflow.
  - NOT 011: ~A.
  - AND 100, OR 101, XOR 110: bitwise on A and B.
  - LHG 111: {B[WIDTH/2-1:0], WIDTH/2 zeros}.
  - Logic ops drive carryout = overflow = 0.
- SHIFT_REG, applied to A by shift_number:
  - SHLEFTLOG 000, SHLEFTART 001: identical left shifts.
  - SHRGHTLOG 010, SHRGHTART 011: logical and arithmetic right shifts.
  - ROTL 100, ROTR 101: new rotates.
  - carryout = last bit shifted or rotated out; 0 when shift_number == 0.
  - overflow = 0.
  - Codes 110 and 111 are illegal.
- MUL, signed A×B with a 2·WIDTH-bit product:
  - MULLO 000: low WIDTH bits. overflow = 1 when the product does not fit in signed WIDTH bits.
  - MULHI 001: high WIDTH bits. overflow = 0.
  - carryout = 0 for both.
  - Other codes are illegal.
- Illegal encodings are accepted and complete with a single-cycle result: aluout = 0, all flags 0 except zero = 1, and illegal = 1.
- State machine:
  - IDLE: an accepted MUL → MUL with iteration counter 0. Every other accepted op writes the result register directly.
  - MUL: one radix-2 iteration per cycle. When the counter reaches WIDTH-1 → DONE.
  - DONE: write the result register, set out_valid → IDLE.
- Result register: aluout and all flags stay stable while out_valid && !out_ready. out_valid clears on a transfer out unless a new result is written in the same cycle.

## Timing
- Reset values: out_valid 0; aluout, carryout, overflow, illegal 0; zero 1; state IDLE; in_ready 1 after reset deasserts, provided out_valid is 0.
- Single-cycle ops: accepted at edge N, out_valid at N+1. Throughput is 1 per cycle while out_ready is held high.
- MUL: accepted at edge N, state MUL for WIDTH cycles, DONE at N+WIDTH, out_valid at N+WIDTH+1. in_ready is 0 from N+1 until the cycle out_valid is presented and out_ready is high.
- A transfer out and a transfer in may occur in the same cycle. The new result overwrites the register and out_valid stays 1.
- Reset mid-MUL aborts the operation: no result is produced and the partial product is discarded.
- Inputs are sampled only on a transfer in. Operand changes afterwards do not affect an in-flight MUL.

## Structure
- Package alu_pkg holds the opselect codes (SHIFT_REG, ARITH_LOGIC, MUL), the operation codes for each unit (including ROTL, ROTR, MULLO, MULHI), and the state enum {IDLE, MUL, DONE}.
- Sub-module alu_mul_seq: the iterative signed multiplier.
  - Inputs: clock, reset, start, a, b.
  - Outputs: done, product[2·WIDTH-1:0].
  - It owns the iteration counter and the sign correction.
- The combinational arith/shift datapath and the flag logic live in alu_pipe.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 → aluout 0x00000000, carryout 1, zero 1, overflow 0, out_valid exactly one cycle after the handshake.
- SUB 0x80000000 − 0x00000001 → 0x7FFFFFFF, overflow 1, carryout 0. SUB 0x1 − 0x2 → 0xFFFFFFFF, carryout 1.
- SHRGHTART 0x80000010 by 4 → 0xF8000001, carryout 0. ROTL 0x80000001 by 1 → 0x00000003, carryout 1. Shift by 0 → A unchanged, carryout 0.
- MULLO −3×5 → 0xFFFFFFF1, overflow 0. MULHI of the same → 0xFFFFFFFF. in_ready is low for 32 cycles and out_valid asserts 33 cycles after acceptance. MULLO 0x10000×0x10000 → 0x00000000, overflow 1.
- Backpressure: stream 4 ADDs with out_ready held low for 3 cycles mid-stream → results in order, aluout stable while stalled, none lost or duplicated.
- Reset pulsed during MUL iteration 10 → out_valid 0 with no result emitted. in_ready is 1 the cycle after reset deasserts, and a following AND completes normally. An illegal opselect 111 → aluout 0, illegal 1, zero 1.
